sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// Control sequencer for a SHA-256 compression core: loads 16 message words, runs ROUNDS rounds, then adds into the hash.
// Optional feature macro: SHA256_MULTIBLOCK_EN (chains hash state across blocks, init_hash only on a message's first block).
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       last_block,
    input  logic       w_valid,
    output logic       w_ready,
    output logic       w_load,
    output logic [3:0] w_idx,
    output logic [6:0] k_sel,
    output logic       round_en,
    output logic       init_hash,
    output logic       final_add,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);
    localparam logic [6:0] K_ZERO   = 7'h7F;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  word_cnt_r;
    logic [6:0]  rnd_cnt_r;
    logic        init_hash_r;
    logic        accept_s;
    logic        first_s;

    assign accept_s = (state_r == ST_IDLE) && start;

`ifdef SHA256_MULTIBLOCK_EN
    logic first_blk_r;
    logic last_blk_r;

    // First-block flag: re-armed when the final block of a message completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_blk_r <= 1'b1;
            last_blk_r  <= 1'b0;
        end else if (accept_s) begin
            first_blk_r <= 1'b0;
            last_blk_r  <= last_block;
        end else if ((state_r == ST_DONE) && last_blk_r) begin
            first_blk_r <= 1'b1;
        end
    end

    assign first_s = first_blk_r;
`else
    logic unused_last_block_s;
    assign unused_last_block_s = last_block;
    assign first_s = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a new start is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_valid && (word_cnt_r == 4'd15)) begin
                    state_s = ST_ROUND;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_ROUND: begin
                if (rnd_cnt_r == LAST_RND) begin
                    state_s = ST_FINAL;
                end else begin
                    state_s = ST_ROUND;
                end
            end
            ST_FINAL: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Word and round counters; word counter wraps to 0 after word 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r  <= 4'd0;
            rnd_cnt_r   <= 7'd0;
            init_hash_r <= 1'b0;
        end else begin
            if (w_load) begin
                word_cnt_r <= word_cnt_r + 4'd1;
            end
            if ((state_r == ST_ROUND) && (rnd_cnt_r != LAST_RND)) begin
                rnd_cnt_r <= rnd_cnt_r + 7'd1;
            end else begin
                rnd_cnt_r <= 7'd0;
            end
            init_hash_r <= accept_s && first_s;
        end
    end

    // Output decode of the registered state; only w_load sees an input.
    always_comb begin
        w_ready   = 1'b0;
        w_idx     = 4'd0;
        k_sel     = K_ZERO;
        round_en  = 1'b0;
        final_add = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_LOAD: begin
                w_ready = 1'b1;
                w_idx   = word_cnt_r;
            end
            ST_ROUND: begin
                round_en = 1'b1;
                k_sel    = rnd_cnt_r;
            end
            ST_FINAL: final_add = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    assign w_load    = w_ready && w_valid;
    assign init_hash = init_hash_r;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: a ROUNDS=64 instance and a ROUNDS=4 instance, hand-derived cycle counts.
module tb_sha256_round_ctrl;

    logic clk = 1'b0;
    logic rst, start_a, start_b, last_block, w_valid;
    logic sel;

    logic a_w_ready, a_w_load, a_round_en, a_init_hash, a_final_add, a_busy, a_done;
    logic [3:0] a_w_idx;
    logic [6:0] a_k_sel;
    logic b_w_ready, b_w_load, b_round_en, b_init_hash, b_final_add, b_busy, b_done;
    logic [3:0] b_w_idx;
    logic [6:0] b_k_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start_a), .last_block(last_block), .w_valid(w_valid),
        .w_ready(a_w_ready), .w_load(a_w_load), .w_idx(a_w_idx), .k_sel(a_k_sel),
        .round_en(a_round_en), .init_hash(a_init_hash), .final_add(a_final_add),
        .busy(a_busy), .done(a_done)
    );

    sha256_round_ctrl #(.ROUNDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_b), .last_block(last_block), .w_valid(w_valid),
        .w_ready(b_w_ready), .w_load(b_w_load), .w_idx(b_w_idx), .k_sel(b_k_sel),
        .round_en(b_round_en), .init_hash(b_init_hash), .final_add(b_final_add),
        .busy(b_busy), .done(b_done)
    );

    wire       m_w_ready   = sel ? b_w_ready   : a_w_ready;
    wire       m_w_load    = sel ? b_w_load    : a_w_load;
    wire [3:0] m_w_idx     = sel ? b_w_idx     : a_w_idx;
    wire [6:0] m_k_sel     = sel ? b_k_sel     : a_k_sel;
    wire       m_round_en  = sel ? b_round_en  : a_round_en;
    wire       m_init_hash = sel ? b_init_hash : a_init_hash;
    wire       m_final_add = sel ? b_final_add : a_final_add;
    wire       m_busy      = sel ? b_busy      : a_busy;
    wire       m_done      = sel ? b_done      : a_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One block from IDLE; counts every strobe and checks indices as they appear.
    task automatic run_block(input logic toggle_v, input logic lb, input logic poke,
                             input int exp_init, input int exp_rounds, input int exp_lat,
                             input string tag);
        int nload, nround, ninit, nfinal, done_cyc;
        nload = 0; nround = 0; ninit = 0; nfinal = 0; done_cyc = -1;
        last_block = lb;
        w_valid = 1'b1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
            w_valid = toggle_v ? ((cyc % 2) == 1) : 1'b1;
            #1;
            if (m_init_hash) ninit++;
            if (m_w_ready) begin
                check_eq({tag, "_widx"}, 32'(m_w_idx), 32'(nload));
                if (m_w_load) nload++;
            end
            if (m_round_en) begin
                if (nround == 0) check_eq({tag, "_loads_at_round"}, 32'(nload), 32'd16);
                check_eq({tag, "_ksel"}, 32'(m_k_sel), 32'(nround));
                nround++;
            end
            if (m_final_add) begin
                nfinal++;
                check_eq({tag, "_final_ksel"}, 32'(m_k_sel), 32'h7F);
                check_eq({tag, "_final_round_en"}, 32'(m_round_en), 32'd0);
            end
            if (m_done) begin
                done_cyc = cyc;
                check_eq({tag, "_done_busy"}, 32'(m_busy), 32'd1);
            end
            set_start(poke && ((m_round_en && nround == 11) || m_done));
            @(posedge clk);
            #1;
        end
        set_start(1'b0);
        check_eq({tag, "_nload"}, 32'(nload), 32'd16);
        check_eq({tag, "_nround"}, 32'(nround), 32'(exp_rounds));
        check_eq({tag, "_nfinal"}, 32'(nfinal), 32'd1);
        check_eq({tag, "_ninit"}, 32'(ninit), 32'(exp_init));
        check_eq({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
        check_eq({tag, "_idle_busy"}, 32'(m_busy), 32'd0);
        tick();
        check_eq({tag, "_no_requeue"}, 32'(m_busy), 32'd0);
    endtask

    logic [3:0] exp_init_v;
    int         rst_seen;
    int         extra;

    initial begin
        sel = 1'b0;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; last_block = 1'b0; w_valid = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        tick();
        rst = 1'b0;
        w_valid = 1'b0;
        #1;
        check_eq("rst_w_ready", 32'(a_w_ready), 32'd0);
        check_eq("rst_w_load", 32'(a_w_load), 32'd0);
        check_eq("rst_w_idx", 32'(a_w_idx), 32'd0);
        check_eq("rst_k_sel", 32'(a_k_sel), 32'h7F);
        check_eq("rst_round_en", 32'(a_round_en), 32'd0);
        check_eq("rst_init_hash", 32'(a_init_hash), 32'd0);
        check_eq("rst_final_add", 32'(a_final_add), 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_done", 32'(a_done), 32'd0);
        check_eq("rst4_k_sel", 32'(b_k_sel), 32'h7F);
        tick();

`ifdef SHA256_MULTIBLOCK_EN
        exp_init_v = 4'b1001;
`else
        exp_init_v = 4'b1111;
`endif
        run_block(1'b0, 1'b0, 1'b0, int'(exp_init_v[3]), 64, 82, "blk1");
        run_block(1'b1, 1'b0, 1'b0, int'(exp_init_v[2]), 64, 97, "blk2_toggle");
        run_block(1'b0, 1'b1, 1'b1, int'(exp_init_v[1]), 64, 82, "blk3_poke");
        run_block(1'b0, 1'b0, 1'b0, int'(exp_init_v[0]), 64, 82, "blk4");

        // Reset in the middle of the round phase.
        w_valid = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        rst_seen = 0;
        for (int i = 0; i < 120 && rst_seen == 0; i++) begin
            if (a_round_en && a_k_sel == 7'd30) rst_seen = 1;
            else tick();
        end
        check_eq("reached_round30", 32'(rst_seen), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(a_busy), 32'd0);
        check_eq("midrst_k_sel", 32'(a_k_sel), 32'h7F);
        check_eq("midrst_round_en", 32'(a_round_en), 32'd0);
        check_eq("midrst_w_ready", 32'(a_w_ready), 32'd0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_final_add || a_done || a_busy) extra++;
            tick();
        end
        check_eq("midrst_quiet", 32'(extra), 32'd0);

        // Reset and start in the same cycle: reset wins.
        rst = 1'b1; start_a = 1'b1;
        tick();
        rst = 1'b0; start_a = 1'b0;
        check_eq("rst_over_start_busy", 32'(a_busy), 32'd0);
        tick();
        check_eq("rst_over_start_busy2", 32'(a_busy), 32'd0);

        run_block(1'b0, 1'b0, 1'b0, 1, 64, 82, "after_rst");

        sel = 1'b1;
        run_block(1'b0, 1'b0, 1'b0, 1, 4, 22, "rounds4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
